// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the decode -> dispatch path.
// - IType, AluFunc, BrFunc: instruction class and function encodings from decode.
// - DispatchTarget: which reservation station a queued instruction goes to.
// - DecodedInst: payload carried through the instruction queue to the stations.
// - route(): maps an instruction class to its reservation station.
package dispatch_ctrl_pkg;

  typedef enum logic [3:0] {
    OP     = 4'd0,
    OPIMM  = 4'd1,
    LUI    = 4'd2,
    AUIPC  = 4'd3,
    BRANCH = 4'd4,
    JAL    = 4'd5,
    JALR   = 4'd6,
    LOAD   = 4'd7,
    STORE  = 4'd8,
    FENCE  = 4'd9,
    SYSTEM = 4'd10
  } IType;

  typedef enum logic [3:0] {
    Add  = 4'd0,
    Sub  = 4'd1,
    Sll  = 4'd2,
    Slt  = 4'd3,
    Sltu = 4'd4,
    Xor  = 4'd5,
    Srl  = 4'd6,
    Sra  = 4'd7,
    Or   = 4'd8,
    And  = 4'd9
  } AluFunc;

  typedef enum logic [2:0] {
    Eq  = 3'd0,
    Neq = 3'd1,
    Lt  = 3'd2,
    Ge  = 3'd3,
    Ltu = 3'd4,
    Geu = 3'd5
  } BrFunc;

  typedef enum logic [1:0] {
    TGT_ALU  = 2'd0,
    TGT_BR   = 2'd1,
    TGT_MEM  = 2'd2,
    TGT_NONE = 2'd3
  } DispatchTarget;

  typedef struct packed {
    IType        iType;
    AluFunc      aluFunc;
    BrFunc       brFunc;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } DecodedInst;

  // Classes without a station (and any unencoded value) map to TGT_NONE.
  function automatic DispatchTarget route(IType t);
    DispatchTarget tgt;
    case (t)
      OP, OPIMM, LUI, AUIPC: tgt = TGT_ALU;
      BRANCH, JAL, JALR:     tgt = TGT_BR;
      LOAD, STORE:           tgt = TGT_MEM;
      default:               tgt = TGT_NONE;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_inst_queue.sv
// inst_queue: DEPTH-entry FIFO of decoded instructions.
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   flush_in         empties the queue (pointers and count to 0)
//   push_in, data_in write one entry (ignored when full)
//   pop_in           retire the head entry (ignored when empty)
//   head_out         head entry, all zeros when empty
//   count_out        occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap by overflow.
module inst_queue
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     flush_in,
  input  logic                     push_in,
  input  DecodedInst               data_in,
  input  logic                     pop_in,
  output DecodedInst               head_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  DecodedInst            mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push_in && (count_q < CntW'(DEPTH));
  assign do_pop  = pop_in && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; stale entries are never visible past count.
  always_ff @(posedge clk_in) begin
    if (do_push && !rst_in && !flush_in) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign head_out  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_out = count_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order dispatch from decode to the ALU, branch and memory
// reservation stations through a small instruction queue.
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset (acts as flush)
//   flush_in                mispredict flush, empties the queue
//   dec_valid_in/ready_out  decode handshake; payload on iType_in..rd_in
//   alu/br/mem_valid_out    head routed to that station (at most one high)
//   alu/br/mem_ready_in     station can accept
//   inst_out                head payload shared by all stations
//   illegal_out             pulse when an unroutable head is dropped
//   count_out               queue occupancy
// Optional: define DISPATCH_STATS_EN to add stall_cnt_out / disp_cnt_out.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   flush_in,
  input  logic                   dec_valid_in,
  output logic                   dec_ready_out,
  input  IType                   iType_in,
  input  AluFunc                 aluFunc_in,
  input  BrFunc                  brFunc_in,
  input  logic [31:0]            pc_in,
  input  logic [31:0]            imm_in,
  input  logic [4:0]             rs1_in,
  input  logic [4:0]             rs2_in,
  input  logic [4:0]             rd_in,
  output logic                   alu_valid_out,
  input  logic                   alu_ready_in,
  output logic                   br_valid_out,
  input  logic                   br_ready_in,
  output logic                   mem_valid_out,
  input  logic                   mem_ready_in,
  output DecodedInst             inst_out,
  output logic                   illegal_out,
  output logic [$clog2(DEPTH):0] count_out
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]            stall_cnt_out,
  output logic [31:0]            disp_cnt_out
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  DecodedInst    head;
  DecodedInst    new_inst;
  logic [CntW-1:0] count;
  logic          empty;
  logic          push, pop, dispatched;
  DispatchTarget tgt;

  assign new_inst = '{
    iType:   iType_in,
    aluFunc: aluFunc_in,
    brFunc:  brFunc_in,
    pc:      pc_in,
    imm:     imm_in,
    rs1:     rs1_in,
    rs2:     rs2_in,
    rd:      rd_in
  };

  assign empty = (count == '0);
  assign tgt   = route(head.iType);

  // No bypass: a full queue refuses even when the head leaves this cycle.
  assign dec_ready_out = !rst_in && (count < CntW'(DEPTH));
  assign push          = dec_valid_in && dec_ready_out;

  // Valids depend only on registered head/count, never on station ready.
  always_comb begin
    alu_valid_out = 1'b0;
    br_valid_out  = 1'b0;
    mem_valid_out = 1'b0;
    illegal_out   = 1'b0;
    if (!rst_in && !empty) begin
      unique case (tgt)
        TGT_ALU:  alu_valid_out = 1'b1;
        TGT_BR:   br_valid_out  = 1'b1;
        TGT_MEM:  mem_valid_out = 1'b1;
        TGT_NONE: illegal_out   = 1'b1;
      endcase
    end
  end

  assign dispatched = (alu_valid_out && alu_ready_in) ||
                      (br_valid_out && br_ready_in) ||
                      (mem_valid_out && mem_ready_in);

  // An unroutable head is dropped without waiting on any station.
  assign pop = dispatched || illegal_out;

  assign inst_out  = rst_in ? '0 : head;
  assign count_out = count;

  inst_queue #(
    .DEPTH(DEPTH)
  ) u_inst_queue (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .flush_in (flush_in),
    .push_in  (push),
    .data_in  (new_inst),
    .pop_in   (pop),
    .head_out (head),
    .count_out(count)
  );

`ifdef DISPATCH_STATS_EN
  logic stalled;
  assign stalled = (alu_valid_out && !alu_ready_in) ||
                   (br_valid_out && !br_ready_in) ||
                   (mem_valid_out && !mem_ready_in);

  // Cleared by reset only; a flush leaves the totals intact.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt_out <= '0;
      disp_cnt_out  <= '0;
    end else begin
      if (stalled)    stall_cnt_out <= stall_cnt_out + 32'd1;
      if (dispatched) disp_cnt_out  <= disp_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, flush_in, dec_valid_in, dec_ready_out;
  IType        iType_in;
  AluFunc      aluFunc_in;
  BrFunc       brFunc_in;
  logic [31:0] pc_in, imm_in;
  logic [4:0]  rs1_in, rs2_in, rd_in;
  logic        alu_valid_out, alu_ready_in, br_valid_out, br_ready_in;
  logic        mem_valid_out, mem_ready_in, illegal_out;
  DecodedInst  inst_out;
  logic [$clog2(DEPTH):0] count_out;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stall_cnt_out, disp_cnt_out;
  logic [31:0] m_stall, m_disp;
`endif

  dispatch_ctrl #(
    .DEPTH(DEPTH)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .flush_in     (flush_in),
    .dec_valid_in (dec_valid_in),
    .dec_ready_out(dec_ready_out),
    .iType_in     (iType_in),
    .aluFunc_in   (aluFunc_in),
    .brFunc_in    (brFunc_in),
    .pc_in        (pc_in),
    .imm_in       (imm_in),
    .rs1_in       (rs1_in),
    .rs2_in       (rs2_in),
    .rd_in        (rd_in),
    .alu_valid_out(alu_valid_out),
    .alu_ready_in (alu_ready_in),
    .br_valid_out (br_valid_out),
    .br_ready_in  (br_ready_in),
    .mem_valid_out(mem_valid_out),
    .mem_ready_in (mem_ready_in),
    .inst_out     (inst_out),
    .illegal_out  (illegal_out),
    .count_out    (count_out)
`ifdef DISPATCH_STATS_EN
    ,
    .stall_cnt_out(stall_cnt_out),
    .disp_cnt_out (disp_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  DecodedInst model_q[$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 0 = ALU, 1 = BR, 2 = MEM, 3 = none.
  function automatic int station_of(IType t);
    if (t inside {OP, OPIMM, LUI, AUIPC}) return 0;
    if (t inside {BRANCH, JAL, JALR}) return 1;
    if (t inside {LOAD, STORE}) return 2;
    return 3;
  endfunction

  task automatic drive_inst(input DecodedInst d);
    iType_in   = d.iType;
    aluFunc_in = d.aluFunc;
    brFunc_in  = d.brFunc;
    pc_in      = d.pc;
    imm_in     = d.imm;
    rs1_in     = d.rs1;
    rs2_in     = d.rs2;
    rd_in      = d.rd;
  endtask

  function automatic DecodedInst mk(input IType t, input logic [31:0] pc, input logic [31:0] imm,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd);
    DecodedInst d;
    d = '{iType: t, aluFunc: Add, brFunc: Eq, pc: pc, imm: imm, rs1: rs1, rs2: rs2, rd: rd};
    return d;
  endfunction

  function automatic DecodedInst rand_inst();
    DecodedInst d;
    if ($urandom_range(0, 9) == 0) d.iType = IType'(4'($urandom_range(9, 15)));
    else d.iType = IType'(4'($urandom_range(0, 8)));
    d.aluFunc = AluFunc'(4'($urandom_range(0, 9)));
    d.brFunc  = BrFunc'(3'($urandom_range(0, 5)));
    d.pc      = $urandom;
    d.imm     = $urandom;
    d.rs1     = 5'($urandom);
    d.rs2     = 5'($urandom);
    d.rd      = 5'($urandom);
    return d;
  endfunction

  // Called 1 time unit after a rising edge with inputs already driven.
  // Checks outputs against the model, advances the model, returns after the next edge.
  task automatic step(input string tag);
    DecodedInst head, cur;
    int st, sz;
    logic e_alu, e_br, e_mem, e_ill, deq, acc;
    #2;
    sz   = model_q.size();
    head = (sz == 0) ? DecodedInst'('0) : model_q[0];
    st   = (sz == 0) ? 4 : station_of(head.iType);
    e_alu = !rst_in && st == 0;
    e_br  = !rst_in && st == 1;
    e_mem = !rst_in && st == 2;
    e_ill = !rst_in && st == 3;
    check_val({tag, ".count"}, count_out, sz);
    check_val({tag, ".dec_ready"}, dec_ready_out, !rst_in && sz < DEPTH);
    check_val({tag, ".alu_valid"}, alu_valid_out, e_alu);
    check_val({tag, ".br_valid"}, br_valid_out, e_br);
    check_val({tag, ".mem_valid"}, mem_valid_out, e_mem);
    check_val({tag, ".illegal"}, illegal_out, e_ill);
    check_val({tag, ".inst"}, inst_out, rst_in ? DecodedInst'('0) : head);
    deq = e_ill || (e_alu && alu_ready_in) || (e_br && br_ready_in) || (e_mem && mem_ready_in);
    acc = dec_valid_in && !rst_in && sz < DEPTH;
`ifdef DISPATCH_STATS_EN
    check_val({tag, ".stall_cnt"}, stall_cnt_out, m_stall);
    check_val({tag, ".disp_cnt"}, disp_cnt_out, m_disp);
    if (rst_in) begin
      m_stall = 0;
      m_disp  = 0;
    end else begin
      if (deq && !e_ill) m_disp++;
      if ((e_alu && !alu_ready_in) || (e_br && !br_ready_in) || (e_mem && !mem_ready_in))
        m_stall++;
    end
`endif
    cur = '{iType: iType_in, aluFunc: aluFunc_in, brFunc: brFunc_in, pc: pc_in, imm: imm_in,
            rs1: rs1_in, rs2: rs2_in, rd: rd_in};
    if (rst_in || flush_in) begin
      model_q.delete();
    end else begin
      if (deq) void'(model_q.pop_front());
      if (acc) model_q.push_back(cur);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_ready(input logic a, input logic b, input logic m);
    alu_ready_in = a;
    br_ready_in  = b;
    mem_ready_in = m;
  endtask

  initial begin
    DecodedInst d;
    rst_in = 1'b1;
    flush_in = 1'b0;
    dec_valid_in = 1'b0;
    set_ready(1'b0, 1'b0, 1'b0);
    drive_inst('0);
`ifdef DISPATCH_STATS_EN
    m_stall = 0;
    m_disp  = 0;
`endif
    repeat (2) @(posedge clk_in);
    #1;
    step("reset");
    rst_in = 1'b0;
    step("post_reset");

    // Single ALU op: add a1,a2,a3.
    set_ready(1'b1, 1'b1, 1'b1);
    d = mk(OP, 32'h1111, 32'h0, 5'd12, 5'd13, 5'd11);
    drive_inst(d);
    dec_valid_in = 1'b1;
    step("alu_push");
    dec_valid_in = 1'b0;
    check_val("alu_valid_after_push", alu_valid_out, 1'b1);
    check_val("alu_inst_after_push", inst_out, d);
    step("alu_disp");
    check_val("alu_count_drained", count_out, 0);

    // In-order blocking behind a stalled STORE.
    set_ready(1'b1, 1'b1, 1'b0);
    dec_valid_in = 1'b1;
    drive_inst(mk(STORE, 32'h2000, 32'd4, 5'd14, 5'd13, 5'd0));
    step("blk_push_st");
    drive_inst(mk(OPIMM, 32'h2004, 32'd1, 5'd0, 5'd0, 5'd11));
    step("blk_push_op");
    dec_valid_in = 1'b0;
    step("blk_hold0");
    step("blk_hold1");
    check_val("blk_alu_blocked", alu_valid_out, 1'b0);
    check_val("blk_mem_held", mem_valid_out, 1'b1);
    mem_ready_in = 1'b1;
    step("blk_st_disp");
    check_val("blk_op_next", alu_valid_out, 1'b1);
    step("blk_op_disp");

    // Full queue: no bypass when popping into a full queue.
    set_ready(1'b0, 1'b0, 1'b0);
    dec_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_inst(mk(OP, 32'h3000 + 32'(i * 4), 32'(i), 5'd1, 5'd2, 5'(i + 3)));
      step("full_push");
    end
    check_val("full_ready_low", dec_ready_out, 1'b0);
    alu_ready_in = 1'b1;
    step("full_pop_push");
    alu_ready_in = 1'b0;
    check_val("full_no_bypass", count_out, 3);
    step("full_enq_next");
    dec_valid_in = 1'b0;
    check_val("full_refilled", count_out, 4);

    // Flush with three queued and a concurrent enqueue.
    set_ready(1'b1, 1'b1, 1'b1);
    repeat (4) step("drain");
    set_ready(1'b0, 1'b0, 1'b0);
    dec_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_inst(mk(LOAD, 32'h4000 + 32'(i * 4), 32'h0, 5'd2, 5'd0, 5'(i + 5)));
      step("fl_push");
    end
    flush_in = 1'b1;
    step("fl_flush");
    flush_in = 1'b0;
    dec_valid_in = 1'b0;
    check_val("fl_count", count_out, 0);
    check_val("fl_mem_valid", mem_valid_out, 1'b0);

    // Unroutable head followed by a branch.
    set_ready(1'b1, 1'b1, 1'b1);
    dec_valid_in = 1'b1;
    drive_inst(mk(FENCE, 32'h5000, 32'h0, 5'd0, 5'd0, 5'd0));
    step("ill_push");
    drive_inst(mk(BRANCH, 32'h5004, 32'h10, 5'd1, 5'd2, 5'd0));
    check_val("ill_pulse", illegal_out, 1'b1);
    step("ill_drop");
    dec_valid_in = 1'b0;
    check_val("ill_pulse_ends", illegal_out, 1'b0);
    check_val("ill_br_next", br_valid_out, 1'b1);
    step("ill_br_disp");

`ifdef DISPATCH_STATS_EN
    rst_in = 1'b1;
    step("st_reset");
    rst_in = 1'b0;
    set_ready(1'b0, 1'b0, 1'b0);
    dec_valid_in = 1'b1;
    drive_inst(mk(OP, 32'h6000, 32'h0, 5'd1, 5'd1, 5'd1));
    step("st_push0");
    step("st_push1");
    dec_valid_in = 1'b0;
    step("st_stall");
    step("st_stall");
    alu_ready_in = 1'b1;
    step("st_disp");
    step("st_disp");
    check_val("st_stall3", stall_cnt_out, 32'd3);
    check_val("st_disp2", disp_cnt_out, 32'd2);
    flush_in = 1'b1;
    step("st_flush");
    flush_in = 1'b0;
    check_val("st_flush_keeps", disp_cnt_out, 32'd2);
    rst_in = 1'b1;
    step("st_rst");
    rst_in = 1'b0;
    check_val("st_rst_clears", stall_cnt_out, 32'd0);
`endif

    // Randomized traffic with occasional flush and reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_in       = ($urandom_range(0, 149) == 0);
      flush_in     = ($urandom_range(0, 39) == 0);
      dec_valid_in = ($urandom_range(0, 3) != 0);
      alu_ready_in = ($urandom_range(0, 9) < 7);
      br_ready_in  = ($urandom_range(0, 9) < 6);
      mem_ready_in = ($urandom_range(0, 9) < 5);
      drive_inst(rand_inst());
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
